key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Input-side front end for the board push-buttons: turns raw, bouncing, active-low key pins into clean, single-cycle press/release event pulses and a debounced level per key. It is the producer of the one-cycle "button pressed" strobes that counters and display logic consume. Optional auto-repeat re-issues press pulses while a key stays held. Sits directly behind the key_i pins, one instance per key group.

Parameters:
KEYS, 2, number of independent key channels
DEBOUNCE_CYCLES, 1000000, cycles a new level must stay stable before it is accepted (10 ms at 100 MHz); minimum 2
REPEAT_EN, 0, 1 enables auto-repeat of press_o while held
REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first repeat pulse; minimum 2
REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; minimum 2

Ports:
clk100_i  in  1  system clock, 100 MHz
rstn_i  in  1  asynchronous active-low reset
key_i  in  KEYS  raw key pins, active-low (0 = pressed), asynchronous to clk100_i
key_state_o  out  KEYS  debounced level, 1 = pressed
press_o  out  KEYS  one-cycle strobe on accepted press and on each auto-repeat
release_o  out  KEYS  one-cycle strobe on accepted release

Behaviour:
- All channels identical and independent; each channel has no interaction with the others.
- Reset (rstn_i low, asynchronous): synchronizer flops set to 1 (released), FSM set to IDLE, all counters 0, key_state_o = 0, press_o = 0, release_o = 0. Reset mid-debounce or mid-hold aborts silently, with no pulse on either edge of reset.
- Synchronizer: two flops per key. Sampled level s = NOT sync[1], so 1 = pressed.
- Debounce counter width: clog2(DEBOUNCE_CYCLES). Repeat counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- The FSM and all outputs are registered.
- IDLE (key_state_o = 0):
  - s = 1 -> PRESS_WAIT, cnt <= 0.
- PRESS_WAIT:
  - s = 0 -> IDLE. This is a bounce: no pulse.
  - s = 1 and cnt = DEBOUNCE_CYCLES-1 -> HELD, press_o = 1 for one cycle, key_state_o <= 1, rpt_cnt <= 0, rpt_lim <= DELAY.
  - Otherwise cnt++.
- HELD (key_state_o = 1):
  - s = 0 -> RELEASE_WAIT, cnt <= 0.
  - Otherwise, if REPEAT_EN: when rpt_cnt = rpt_lim-1, press_o = 1 for one cycle, rpt_cnt <= 0, rpt_lim <= PERIOD; else rpt_cnt++.
  - If REPEAT_EN = 0, rpt_cnt stays 0.
- RELEASE_WAIT (key_state_o stays 1):
  - s = 1 -> HELD. This is a bounce: no pulse. rpt_cnt and rpt_lim are held, not reset.
  - s = 0 and cnt = DEBOUNCE_CYCLES-1 -> IDLE, release_o = 1 for one cycle, key_state_o <= 0.
  - Otherwise cnt++. rpt_cnt is frozen throughout this state.
- Latency: pin asserts stably, and E0 is the first rising edge that captures it. The state change occurs at edge E0+2+DEBOUNCE_CYCLES, and press_o (or release_o) is high for the cycle that follows that edge. The same rule applies to release.
- Any glitch shorter than DEBOUNCE_CYCLES consecutive samples produces no event.
- Exactly one press pulse and one release pulse per accepted press/release pair, excluding repeats.
- press_o and release_o are never high in the same cycle on the same channel. They are never high for two consecutive cycles.
- Counters never wrap. They saturate only by state exit, since the compare occurs before increment.

Test Plan:
Common bench settings: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, KEYS=2.
1. Clean press: key_i[0] 1->0 captured at edge E0 -> press_o[0] high only in the cycle after edge E0+6, key_state_o[0] goes 1 at the same edge; release gives release_o[0] at the same +6 offset, key_state_o[0] returns to 0.
2. Bounce: key_i[0] low for 3 cycles, high for 1, repeated 5 times, then steady low -> no pulse during bouncing; exactly one press_o[0] pulse, 6 edges after the final steady low is captured.
3. Release bounce: while held, key_i[0] high for 2 cycles, then low again -> no release_o, key_state_o stays 1, no extra press_o.
4. Auto-repeat (REPEAT_EN=1): hold 40 cycles past the press pulse -> repeat pulses 10, 15, 20, 25, 30, 35, 40 cycles after the initial pulse. With REPEAT_EN=0 -> only the initial pulse.
5. Reset mid-debounce: rstn_i low at cnt=2 in PRESS_WAIT, key still low, released after 3 cycles -> all outputs 0 during reset, no pulse during reset; the press is then re-debounced from scratch, giving press_o 6 edges after the first post-reset capture.
6. Independence: press key 0 and key 1 one cycle apart -> press_o[0] and press_o[1] each fire once, one cycle apart; releasing one key does not disturb the other.

Source files
------------

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced push-button front end with press/release strobes and optional auto-repeat
module key_conditioner #(
    parameter int KEYS            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            clk100_i,
    input  logic            rstn_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] key_state_o,
    output logic [KEYS-1:0] press_o,
    output logic [KEYS-1:0] release_o
);

    localparam int DCW     = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW     = $clog2(RPT_MAX);

    // Terminal counts are stored as "limit - 1" so they always fit the counter width.
    localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [KEYS-1:0] sync0;
    logic [KEYS-1:0] sync1;

    // Two-flop synchronizer; resets to the released (high) pin level.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync0 <= '1;
            sync1 <= '1;
        end else begin
            sync0 <= key_i;
            sync1 <= sync0;
        end
    end

    for (genvar g = 0; g < KEYS; g++) begin : g_ch
        state_t         state, state_nx;
        logic [DCW-1:0] cnt, cnt_nx;
        logic [RCW-1:0] rpt_cnt, rpt_cnt_nx;
        logic [RCW-1:0] rpt_last, rpt_last_nx;
        logic           level, level_nx;
        logic           press_q, press_nx;
        logic           release_q, release_nx;
        logic           s;

        // Sampled level, 1 = pressed.
        assign s = ~sync1[g];

        // Per-channel state, counters and registered outputs.
        always_ff @(posedge clk100_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state     <= IDLE;
                cnt       <= '0;
                rpt_cnt   <= '0;
                rpt_last  <= '0;
                level     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                rpt_cnt   <= rpt_cnt_nx;
                rpt_last  <= rpt_last_nx;
                level     <= level_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
            end
        end

        // Debounce / hold FSM; the compare precedes the increment so counters never wrap.
        always_comb begin
            state_nx    = state;
            cnt_nx      = cnt;
            rpt_cnt_nx  = rpt_cnt;
            rpt_last_nx = rpt_last;
            level_nx    = level;
            press_nx    = 1'b0;
            release_nx  = 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_nx = IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state_nx    = HELD;
                        press_nx    = 1'b1;
                        level_nx    = 1'b1;
                        rpt_cnt_nx  = '0;
                        rpt_last_nx = DELAY_LAST;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx   = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rpt_cnt == rpt_last) begin
                            press_nx    = 1'b1;
                            rpt_cnt_nx  = '0;
                            rpt_last_nx = PERIOD_LAST;
                        end else begin
                            rpt_cnt_nx = rpt_cnt + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed resumes the repeat schedule where it froze.
                    if (s) begin
                        state_nx = HELD;
                    end else if (cnt == DEB_LAST) begin
                        state_nx   = IDLE;
                        release_nx = 1'b1;
                        level_nx   = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end

        assign key_state_o[g] = level;
        assign press_o[g]     = press_q;
        assign release_o[g]   = release_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner
module tb_key_conditioner;

    localparam int KEYS = 2;
    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;

    logic            clk = 1'b0;
    logic            rstn;
    logic [KEYS-1:0] key;
    logic [KEYS-1:0] st_n, pr_n, rl_n;
    logic [KEYS-1:0] st_r, pr_r, rl_r;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .KEYS(KEYS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk100_i(clk), .rstn_i(rstn), .key_i(key),
        .key_state_o(st_n), .press_o(pr_n), .release_o(rl_n)
    );

    key_conditioner #(
        .KEYS(KEYS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_r (
        .clk100_i(clk), .rstn_i(rstn), .key_i(key),
        .key_state_o(st_r), .press_o(pr_r), .release_o(rl_r)
    );

    typedef struct {
        int         n;
        logic [1:0] key;
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [1:0] k, input logic [1:0] st,
                       input logic [1:0] pr, input logic [1:0] rl);
        vec_t v;
        v.n = n; v.key = k; v.st = st; v.pr = pr; v.rl = rl;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [1:0] k, input logic r);
        @(posedge clk);
        #1;
        key  = k;
        rstn = r;
        @(negedge clk);
        step_no++;
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%b expected=%b", name, step_no, act, exp);
        end
    endtask

    task automatic chk_all(input logic [1:0] st, input logic [1:0] prn,
                           input logic [1:0] prr, input logic [1:0] rl);
        chk("state", st_n, st);
        chk("press", pr_n, prn);
        chk("release", rl_n, rl);
        chk("state_rpt", st_r, st);
        chk("press_rpt", pr_r, prr);
        chk("release_rpt", rl_r, rl);
    endtask

    initial begin
        rstn = 1'b0;
        key  = 2'b11;

        // reset state
        repeat (3) begin
            @(negedge clk);
            chk_all(2'b00, 2'b00, 2'b00, 2'b00);
        end
        repeat (3) begin
            step(2'b11, 1'b1);
            chk_all(2'b00, 2'b00, 2'b00, 2'b00);
        end

        // clean press/release on key 0
        add(7, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 2'b01, 2'b01, 2'b00);
        add(2, 2'b10, 2'b01, 2'b00, 2'b00);
        add(7, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b01);
        add(3, 2'b11, 2'b00, 2'b00, 2'b00);
        // press bounce then steady press
        for (int b = 0; b < 5; b++) begin
            add(3, 2'b10, 2'b00, 2'b00, 2'b00);
            add(1, 2'b11, 2'b00, 2'b00, 2'b00);
        end
        add(7, 2'b10, 2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 2'b01, 2'b01, 2'b00);
        // release bounce while held
        add(2, 2'b10, 2'b01, 2'b00, 2'b00);
        add(2, 2'b11, 2'b01, 2'b00, 2'b00);
        add(12, 2'b10, 2'b01, 2'b00, 2'b00);
        add(7, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b01);
        add(3, 2'b11, 2'b00, 2'b00, 2'b00);
        // independence: key 0 then key 1 one cycle later
        add(1, 2'b10, 2'b00, 2'b00, 2'b00);
        add(6, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 2'b00, 2'b01, 2'b01, 2'b00);
        add(1, 2'b00, 2'b11, 2'b10, 2'b00);
        add(3, 2'b00, 2'b11, 2'b00, 2'b00);
        add(7, 2'b10, 2'b11, 2'b00, 2'b00);
        add(1, 2'b10, 2'b01, 2'b00, 2'b10);
        add(3, 2'b10, 2'b01, 2'b00, 2'b00);
        add(7, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 2'b11, 2'b00, 2'b00, 2'b01);
        add(3, 2'b11, 2'b00, 2'b00, 2'b00);

        for (int j = 0; j < tbl.size(); j++) begin
            for (int r = 0; r < tbl[j].n; r++) begin
                step(tbl[j].key, 1'b1);
                chk("state", st_n, tbl[j].st);
                chk("press", pr_n, tbl[j].pr);
                chk("release", rl_n, tbl[j].rl);
                chk("state_rpt", st_r, tbl[j].st);
                chk("release_rpt", rl_r, tbl[j].rl);
            end
        end

        // auto-repeat: initial pulse at 7, repeats every 10 then 5 cycles while held
        for (int i = 0; i < 64; i++) begin
            logic [1:0] e_st, e_prn, e_prr, e_rl;
            step((i < 53) ? 2'b10 : 2'b11, 1'b1);
            e_st  = {1'b0, (i >= 7 && i < 60)};
            e_prn = {1'b0, (i == 7)};
            e_prr = {1'b0, (i == 7) || (i >= 17 && i <= 52 && ((i - 17) % 5) == 0)};
            e_rl  = {1'b0, (i == 60)};
            chk_all(e_st, e_prn, e_prr, e_rl);
        end

        // reset mid-debounce: press re-debounced from the first post-reset capture
        for (int i = 0; i < 26; i++) begin
            logic [1:0] e_st, e_pr, e_rl;
            step((i < 16) ? 2'b10 : 2'b11, !(i >= 5 && i < 8));
            e_st = {1'b0, (i >= 15 && i < 23)};
            e_pr = {1'b0, (i == 15)};
            e_rl = {1'b0, (i == 23)};
            chk_all(e_st, e_pr, e_pr, e_rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
